// File: rtl/rf_bypass_sb_pkg.sv
// Shared CPU definitions for the register file slice: default sizes, the
// hardwired-zero register index and the clear sequencer state type.
package rf_bypass_sb_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned REG_ZERO = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/rf_bypass_sb_scoreboard.sv
// Per-register pending vector for hazard detection. Issue sets a bit and
// writeback clears it, with set winning. Lookups see same-cycle clears.
module rf_bypass_sb_scoreboard #(
   parameter int unsigned NREG   = 32,
   parameter bit          BYPASS = 1'b1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_i,
   input  logic [AW-1:0] set_idx_i,
   input  logic          clr0_i,
   input  logic [AW-1:0] clr0_idx_i,
   input  logic          clr1_i,
   input  logic [AW-1:0] clr1_idx_i,
   input  logic          wipe_i,
   input  logic [AW-1:0] wipe_idx_i,
   input  logic [AW-1:0] ra1_i,
   input  logic [AW-1:0] ra2_i,
   output logic          pend1_o,
   output logic          pend2_o
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   // Set is applied last so an issue overrides a same-cycle writeback.
   always_comb begin
      pend_d = pend_q;
      if (clr0_i) pend_d[clr0_idx_i] = 1'b0;
      if (clr1_i) pend_d[clr1_idx_i] = 1'b0;
      if (wipe_i) pend_d[wipe_idx_i] = 1'b0;
      if (set_i)  pend_d[set_idx_i]  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   function automatic logic lookup(input logic [AW-1:0] ra);
      logic wr_hit;
      logic iss_hit;
      wr_hit  = (clr0_i && (clr0_idx_i == ra)) || (clr1_i && (clr1_idx_i == ra));
      iss_hit = set_i && (set_idx_i == ra);
      if (BYPASS && wr_hit && !iss_hit) return 1'b0;
      return pend_q[ra];
   endfunction

   always_comb begin
      pend1_o = lookup(ra1_i);
      pend2_o = lookup(ra2_i);
   end

endmodule

// File: rtl/rf_bypass_sb.sv
// Two-write / two-read register file with write-through bypass, pending
// scoreboard and a sequenced clear that walks every clearable register.
module rf_bypass_sb
   import rf_bypass_sb_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREG     = NREG_DEF,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we0_i,
   input  logic [AW-1:0]   wa0_i,
   input  logic [XLEN-1:0] wd0_i,
   input  logic            we1_i,
   input  logic [AW-1:0]   wa1_i,
   input  logic [XLEN-1:0] wd1_i,
   input  logic [AW-1:0]   ra1_i,
   input  logic [AW-1:0]   ra2_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o,
   output logic            pend1_o,
   output logic            pend2_o,
   input  logic            iss_valid_i,
   input  logic [AW-1:0]   iss_rd_i,
   input  logic            clr_req_i,
   output logic            clr_busy_o,
   input  logic [AW-1:0]   dbg_addr_i,
   output logic [XLEN-1:0] dbg_data_o
);

   localparam logic [AW-1:0] FIRST_IDX = AW'(ZERO_REG);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

   clr_state_e      state_q;
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] dbg_data_q;

   logic busy;
   logic wr0;
   logic wr1;
   logic iss;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == AW'(REG_ZERO));
   endfunction

   // Writeback and issue are frozen while the clear sequence owns the array.
   assign busy       = (state_q == CLEAR);
   assign wr0        = we0_i && !busy && !is_zero(wa0_i);
   assign wr1        = we1_i && !busy && !is_zero(wa1_i);
   assign iss        = iss_valid_i && !busy && !is_zero(iss_rd_i);
   assign clr_busy_o = busy;
   assign dbg_data_o = dbg_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req_i) begin
                  state_q <= CLEAR;
                  idx_q   <= FIRST_IDX;
               end
            end
            CLEAR: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
               end else begin
                  idx_q   <= idx_q + AW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
            end
         endcase
      end
   end

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_q <= '{default: '0};
      end else if (busy) begin
         rf_q[idx_q] <= '0;
      end else begin
         if (wr0) rf_q[wa0_i] <= wd0_i;
         if (wr1) rf_q[wa1_i] <= wd1_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    dbg_data_q <= '0;
      else if (is_zero(dbg_addr_i)) dbg_data_q <= '0;
      else                        dbg_data_q <= rf_q[dbg_addr_i];
   end

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
      if (is_zero(ra))                   return '0;
      if (BYPASS && wr1 && (wa1_i == ra)) return wd1_i;
      if (BYPASS && wr0 && (wa0_i == ra)) return wd0_i;
      return rf_q[ra];
   endfunction

   always_comb begin
      rd1_o = read_port(ra1_i);
      rd2_o = read_port(ra2_i);
   end

   rf_bypass_sb_scoreboard #(
      .NREG   (NREG),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_i      (iss),
      .set_idx_i  (iss_rd_i),
      .clr0_i     (wr0),
      .clr0_idx_i (wa0_i),
      .clr1_i     (wr1),
      .clr1_idx_i (wa1_i),
      .wipe_i     (busy),
      .wipe_idx_i (idx_q),
      .ra1_i      (ra1_i),
      .ra2_i      (ra2_i),
      .pend1_o    (pend1_o),
      .pend2_o    (pend2_o)
   );

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Randomised and directed bench for rf_bypass_sb against an array-based
// reference model of the register file, pending bits and clear sequence.
module tb_rf_bypass_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            we0, we1, iss_valid, clr_req;
   logic [AW-1:0]   wa0, wa1, ra1, ra2, iss_rd, dbg_addr;
   logic [XLEN-1:0] wd0, wd1;
   logic [XLEN-1:0] rd1, rd2, dbg_data;
   logic            pend1, pend2, clr_busy;

   // reference model state
   logic [XLEN-1:0] mem [NREG];
   logic            pnd [NREG];
   int              clr_left;
   int              clr_ptr;
   logic [XLEN-1:0] dbg_exp;

   int n_chk = 0;
   int n_err = 0;
   int cnt;

   always #5 clk = ~clk;

   rf_bypass_sb #(
      .XLEN(XLEN), .NREG(NREG), .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) dut (
      .clk(clk), .rst(rst),
      .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
      .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
      .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1), .rd2_o(rd2),
      .pend1_o(pend1), .pend2_o(pend2),
      .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
      .clr_req_i(clr_req), .clr_busy_o(clr_busy),
      .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
      if (ra == 0) return '0;
      if (clr_left == 0 && we1 && wa1 == ra) return wd1;
      if (clr_left == 0 && we0 && wa0 == ra) return wd0;
      return mem[ra];
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] ra);
      logic wr_hit;
      if (ra == 0) return 1'b0;
      wr_hit = (we0 && wa0 == ra) || (we1 && wa1 == ra);
      if (clr_left == 0 && wr_hit && !(iss_valid && iss_rd == ra)) return 1'b0;
      return pnd[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         mem[i] = '0;
         pnd[i] = 1'b0;
      end
      clr_left = 0;
      clr_ptr  = 0;
      dbg_exp  = '0;
   endtask

   task automatic model_update();
      dbg_exp = (dbg_addr == 0) ? '0 : mem[dbg_addr];
      if (clr_left > 0) begin
         mem[clr_ptr] = '0;
         pnd[clr_ptr] = 1'b0;
         clr_ptr++;
         clr_left--;
      end else begin
         if (we0 && wa0 != 0) begin mem[wa0] = wd0; pnd[wa0] = 1'b0; end
         if (we1 && wa1 != 0) begin mem[wa1] = wd1; pnd[wa1] = 1'b0; end
         if (iss_valid && iss_rd != 0) pnd[iss_rd] = 1'b1;
         if (clr_req) begin
            clr_left = NREG - 1;
            clr_ptr  = 1;
         end
      end
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; iss_valid = 0; clr_req = 0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      ra1 = '0; ra2 = '0; iss_rd = '0; dbg_addr = '0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic step();
      #2;
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
      check("pend1", 32'(pend1), 32'(exp_pend(ra1)));
      check("pend2", 32'(pend2), 32'(exp_pend(ra2)));
      check("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
      check("dbg_data", dbg_data, dbg_exp);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic sweep_reads();
      for (int i = 0; i < NREG; i++) begin
         idle();
         ra1 = AW'(i); ra2 = AW'(NREG - 1 - i); dbg_addr = AW'(i);
         step();
      end
   endtask

   task automatic fill_index();
      for (int i = 1; i < NREG; i++) begin
         idle();
         we0 = 1; wa0 = AW'(i); wd0 = XLEN'(i);
         step();
      end
      idle();
   endtask

   task automatic run_clear_and_count();
      idle(); clr_req = 1;
      step();
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (!clr_busy) break;
         cnt++;
         idle();
         we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = $urandom;
         we1 = 1'($urandom); wa1 = AW'($urandom); wd1 = $urandom;
         iss_valid = 1'($urandom); iss_rd = AW'($urandom);
         clr_req = 1'($urandom);
         ra1 = AW'($urandom); ra2 = AW'($urandom); dbg_addr = AW'($urandom);
         step();
      end
      idle();
      check("clr_len", 32'(cnt), 32'd31);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      sweep_reads();

      // port 0 write then read back
      idle(); we0 = 1; wa0 = 5'd5; wd0 = 32'h1234_5678;
      step();
      idle(); ra1 = 5'd5; ra2 = 5'd0;
      #1;
      check("t1_rd1", rd1, 32'h1234_5678);
      check("t1_rd2", rd2, 32'h0);
      step();

      // same-address collision, port 1 wins
      idle(); we0 = 1; wa0 = 5'd7; wd0 = 32'hAAAA_AAAA;
      we1 = 1; wa1 = 5'd7; wd1 = 32'h5555_5555; ra1 = 5'd7;
      #1;
      check("t2_byp", rd1, 32'h5555_5555);
      step();
      idle(); ra1 = 5'd7;
      #1;
      check("t2_arr", rd1, 32'h5555_5555);
      step();

      // r0 stays zero and never pending
      idle(); we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
      iss_valid = 1; iss_rd = 5'd0; ra1 = 5'd0;
      step();
      idle(); ra1 = 5'd0;
      #1;
      check("t3_rd1", rd1, 32'h0);
      check("t3_pend", 32'(pend1), 32'd0);
      step();

      // scoreboard set / bypass clear / set wins
      idle(); iss_valid = 1; iss_rd = 5'd9;
      step();
      idle(); ra1 = 5'd9;
      #1;
      check("t4_set", 32'(pend1), 32'd1);
      step();
      idle(); we1 = 1; wa1 = 5'd9; wd1 = 32'h42; ra1 = 5'd9;
      #1;
      check("t4_clr", 32'(pend1), 32'd0);
      check("t4_rd", rd1, 32'h42);
      step();
      idle(); iss_valid = 1; iss_rd = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h7;
      step();
      idle(); ra1 = 5'd9;
      #1;
      check("t4_win", 32'(pend1), 32'd1);
      step();

      // full clear sequence
      fill_index();
      run_clear_and_count();
      sweep_reads();

      // reset in the middle of a clear
      fill_index();
      idle(); clr_req = 1;
      step();
      for (int k = 0; k < 9; k++) begin
         idle();
         step();
      end
      idle(); ra1 = 5'd20;
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_busy", 32'(clr_busy), 32'd0);
      check("t6_rd", rd1, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sweep_reads();
      fill_index();
      run_clear_and_count();
      sweep_reads();

      // random traffic
      for (int k = 0; k < 800; k++) begin
         idle();
         we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = $urandom;
         we1 = 1'($urandom); wa1 = AW'($urandom); wd1 = $urandom;
         iss_valid = 1'($urandom); iss_rd = AW'($urandom);
         clr_req = ($urandom_range(0, 49) == 0);
         ra1 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom);
         ra2 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
         dbg_addr = AW'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
